sdm_cic_dec: RTL and testbench

SDM_CIC_DEC -- requirements
Module: sdm_cic_dec

---
 rtl/sdm_cic_dec.sv | 152 +++++++++++++++
 tb/tb_sdm_cic_dec.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/sdm_cic_dec.sv
// sdm_cic_dec: 1-bit sigma-delta to PCM decimator built on a third-order CIC
// (sinc3, differential delay 1, decimation R = 2^OSR_LOG2) with a 2-stage
// post-decimation pipeline, output shift/saturation and a valid/ready holding
// register with newest-wins overwrite.
// Optional feature macro: SDM_DEC_OVERRUN_EN enables the sticky overrun flag;
// when undefined, overrun is tied to 0.
module sdm_cic_dec #(
  parameter int unsigned DOUT_W   = 16,
  parameter int unsigned OSR_LOG2 = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     din,
  input  logic                     din_valid,
  output logic signed [DOUT_W-1:0] dout,
  output logic                     dout_valid,
  input  logic                     dout_ready,
  output logic                     overrun
);

  localparam int unsigned W = 3 * OSR_LOG2 + 2;
  localparam int unsigned S = 3 * OSR_LOG2 - (DOUT_W - 1);

  localparam logic signed [W-1:0] SAT_MAX = {{(W-DOUT_W+1){1'b0}}, {(DOUT_W-1){1'b1}}};
  localparam logic signed [W-1:0] SAT_MIN = {{(W-DOUT_W+1){1'b1}}, {(DOUT_W-1){1'b0}}};

  logic signed [W-1:0]        r_int1, r_int2, r_int3;
  logic        [OSR_LOG2-1:0] r_cnt;
  logic signed [W-1:0]        r_cap;
  logic                       r_evt1;
  logic signed [W-1:0]        r_d1, r_d2, r_d3;
  logic signed [W-1:0]        r_comb;
  logic                       r_evt2;
  logic        [1:0]          r_tcnt;
  logic signed [DOUT_W-1:0]   r_dout;
  logic                       r_dout_valid;

  logic signed [W-1:0]        w_x;
  logic signed [W-1:0]        w_int1, w_int2, w_int3;
  logic                       w_dec;
  logic signed [W-1:0]        w_c1, w_c2, w_c3;
  logic signed [W-1:0]        w_shift;
  logic signed [DOUT_W-1:0]   w_sat;

  // Bit mapping (+1 / -1) and the updated integrator cascade for this edge
  always_comb begin
    w_x    = din ? {{(W-1){1'b0}}, 1'b1} : {W{1'b1}};
    w_int1 = r_int1 + w_x;
    w_int2 = r_int2 + w_int1;
    w_int3 = r_int3 + w_int2;
    w_dec  = din_valid && (r_cnt == {OSR_LOG2{1'b1}});
  end

  // Comb cascade, output scaling and saturation
  always_comb begin
    w_c1    = r_cap - r_d1;
    w_c2    = w_c1 - r_d2;
    w_c3    = w_c2 - r_d3;
    w_shift = r_comb >>> S;
    w_sat   = DOUT_W'(w_shift);
    if (w_shift > SAT_MAX) begin
      w_sat = SAT_MAX[DOUT_W-1:0];
    end else if (w_shift < SAT_MIN) begin
      w_sat = SAT_MIN[DOUT_W-1:0];
    end
  end

  // Integrators and decimation counter advance only on accepted bits
  always_ff @(posedge clk) begin
    if (rst) begin
      r_int1 <= '0;
      r_int2 <= '0;
      r_int3 <= '0;
      r_cnt  <= '0;
    end else if (din_valid) begin
      r_int1 <= w_int1;
      r_int2 <= w_int2;
      r_int3 <= w_int3;
      r_cnt  <= r_cnt + OSR_LOG2'(1);
    end
  end

  // Decimation event: capture the last integrator's updated value
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cap  <= '0;
      r_evt1 <= 1'b0;
    end else begin
      r_evt1 <= w_dec;
      if (w_dec) begin
        r_cap <= w_int3;
      end
    end
  end

  // Comb stage plus suppression of the first three (transient) events
  always_ff @(posedge clk) begin
    if (rst) begin
      r_d1   <= '0;
      r_d2   <= '0;
      r_d3   <= '0;
      r_comb <= '0;
      r_tcnt <= '0;
      r_evt2 <= 1'b0;
    end else begin
      r_evt2 <= r_evt1 && (r_tcnt == 2'd3);
      if (r_evt1) begin
        r_d1   <= r_cap;
        r_d2   <= w_c1;
        r_d3   <= w_c2;
        r_comb <= w_c3;
        if (r_tcnt != 2'd3) begin
          r_tcnt <= r_tcnt + 2'd1;
        end
      end
    end
  end

  // Output holding register: new sample always wins, transfer clears valid
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
    end else if (r_evt2) begin
      r_dout       <= w_sat;
      r_dout_valid <= 1'b1;
    end else if (r_dout_valid && dout_ready) begin
      r_dout_valid <= 1'b0;
    end
  end

  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;

`ifdef SDM_DEC_OVERRUN_EN
  logic r_overrun;

  // Sticky flag: a pending, unaccepted sample was overwritten
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overrun <= 1'b0;
    end else if (r_evt2 && r_dout_valid && !dout_ready) begin
      r_overrun <= 1'b1;
    end
  end

  assign overrun = r_overrun;
`else
  assign overrun = 1'b0;
`endif

endmodule

// File: tb/tb_sdm_cic_dec.sv
// tb_sdm_cic_dec: directed scenarios for sdm_cic_dec with a queue scoreboard.
// The driver pushes {expected value, expected cycle} on each decimating bit;
// a negedge monitor pops and compares on every transfer.
module tb_sdm_cic_dec;

  typedef struct {
    logic signed [15:0] val;
    int                 cyc;
  } exp_t;

`ifdef SDM_DEC_OVERRUN_EN
  localparam int EXP_OVR = 1;
`else
  localparam int EXP_OVR = 0;
`endif

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               din = 1'b0;
  logic               din_valid = 1'b0;
  logic signed [15:0] dout;
  logic               dout_valid;
  logic               dout_ready = 1'b1;
  logic               overrun;

  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  int   nacc   = 0;
  int   nev    = 0;
  int   pidx   = 0;
  exp_t sb[$];

  sdm_cic_dec #(.DOUT_W(16), .OSR_LOG2(6)) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_valid  (din_valid),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every transfer must match the oldest expected entry
  always @(negedge clk) begin
    if (dout_valid === 1'b1 && dout_ready === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_sample dout=%0d cyc=%0d (none expected)", dout, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (dout !== e.val || (e.cyc >= 0 && cyc != e.cyc)) begin
          errors++;
          $display("FAIL sample dout=%0d at cyc %0d, expected %0d at cyc %0d",
                   dout, cyc, e.val, e.cyc);
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Reset asserted together with din_valid/dout_ready to show reset priority
  task automatic do_reset();
    rst        = 1'b1;
    din        = 1'b1;
    din_valid  = 1'b1;
    dout_ready = 1'b1;
    step(2);
    rst       = 1'b0;
    din_valid = 1'b0;
    nacc = 0;
    nev  = 0;
    pidx = 0;
    chk("reset_dout", int'(dout), 0);
    chk("reset_valid", int'(dout_valid), 0);
    chk("reset_overrun", int'(overrun), 0);
  endtask

  // Drive ncyc clocks of a repeating pattern (bit 0 first); push expectations
  task automatic run(input int ncyc, input logic [3:0] pat, input int plen,
                     input bit dv_toggle, input bit push_en,
                     input logic signed [15:0] expv);
    for (int i = 0; i < ncyc; i++) begin
      logic dv;
      dv        = dv_toggle ? ((i % 2) == 0) : 1'b1;
      din       = pat[pidx];
      din_valid = dv;
      step(1);
      if (dv) begin
        pidx = (pidx + 1) % plen;
        nacc++;
        if ((nacc % 64) == 0) begin
          nev++;
          if (push_en && nev >= 4) begin
            exp_t e;
            e.val = expv;
            e.cyc = cyc + 2;
            sb.push_back(e);
          end
        end
      end
    end
    din_valid = 1'b0;
  endtask

  task automatic drain();
    step(4);
    chk("scoreboard_drained", sb.size(), 0);
  endtask

  initial begin
    // All ones: first valid at event 4, saturated to +32767
    do_reset();
    run(320, 4'b1111, 4, 1'b0, 1'b1, 16'sd32767);
    drain();

    // All zeros: -2^18 >> 3 fits exactly
    do_reset();
    run(320, 4'b0000, 4, 1'b0, 1'b1, -16'sd32768);
    drain();

    // Alternating 1,0 averages to zero
    do_reset();
    run(384, 4'b0101, 2, 1'b0, 1'b1, 16'sd0);
    drain();

    // 1,1,1,0 gives mean +0.5 -> 2^17 >> 3
    do_reset();
    run(320, 4'b0111, 4, 1'b0, 1'b1, 16'sd16384);
    drain();

    // din_valid toggling: same values, period doubled
    do_reset();
    run(640, 4'b1111, 4, 1'b1, 1'b1, 16'sd32767);
    drain();

    // Stall across events 4..6: newest wins, valid held
    do_reset();
    dout_ready = 1'b0;
    run(384, 4'b0111, 4, 1'b0, 1'b0, 16'sd0);
    step(3);
    chk("stall_valid", int'(dout_valid), 1);
    chk("stall_dout", int'(dout), 16384);
    chk("stall_overrun", int'(overrun), EXP_OVR);
    begin
      exp_t e;
      e.val = 16'sd16384;
      e.cyc = -1;
      sb.push_back(e);
    end
    dout_ready = 1'b1;
    step(1);
    chk("after_transfer_valid", int'(dout_valid), 0);
    chk("overrun_sticky", int'(overrun), EXP_OVR);
    step(2);
    chk("overrun_still_sticky", int'(overrun), EXP_OVR);
    chk("scoreboard_drained", sb.size(), 0);

    // Mid-frame reset discards the partial frame and restarts suppression
    do_reset();
    run(30, 4'b1111, 4, 1'b0, 1'b0, 16'sd0);
    do_reset();
    run(320, 4'b1111, 4, 1'b0, 1'b1, 16'sd32767);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
